fir_coef_reload_ctrl: RTL
=========================

// Module: fir_coef_reload_ctrl
// PURPOSE
//  AXI-Stream master that feeds the FIR compiler's s_axis_reload and s_axis_config slave channels.
//  Holds one NUM_TAPS-deep coefficient bank, written by a simple host port.
//  On a start pulse it streams the bank as one reload packet with tlast on the final word,
//  then sends one config word so the FIR compiler applies the new coefficients.
//  Sits beside the FIR wrapper in the aclk (300 MHz) domain; the host port is synchronous to the same clock.
// PARAMETERS
//  NUM_TAPS   32  coefficient words per reload packet (>=2)
//  COEF_W     16  reload tdata width, signed coefficient
//  CFG_W       8  config tdata width
//  AW         $clog2(NUM_TAPS)  coefficient address width (derived, localparam)
// PORTS
//  clk_i                      in   1       single clock (FIR aclk)
//  rstn_i                     in   1       asynchronous, active-low reset
//  coef_wr_en_i               in   1       write strobe to coefficient bank
//  coef_wr_addr_i             in   AW      tap index, 0 = first word streamed
//  coef_wr_data_i             in   COEF_W  coefficient value
//  reload_start_i             in   1       1-cycle pulse: begin reload sequence
//  cfg_sel_i                  in   CFG_W   coefficient-set select, sampled at start
//  m_axis_reload_tdata        out  COEF_W  reload word
//  m_axis_reload_tvalid       out  1
//  m_axis_reload_tlast        out  1       high with word NUM_TAPS-1 only
//  m_axis_reload_tready       in   1
//  m_axis_config_tdata        out  CFG_W   latched cfg_sel
//  m_axis_config_tvalid       out  1
//  m_axis_config_tready       in   1
//  event_tlast_missing_i      in   1       FIR event_s_reload_tlast_missing
//  event_tlast_unexpected_i   in   1       FIR event_s_reload_tlast_unexpected
//  err_clr_i                  in   1       clears err_o
//  busy_o                     out  1       high from the start-accept cycle to the done cycle
//  done_o                     out  1       1-cycle pulse after config handshake
//  err_o                      out  3       sticky: [0] tlast_missing, [1] tlast_unexpected, [2] write while busy
// BEHAVIOUR
//  Reset values
//  - All tvalid, tlast, busy_o, done_o and err_o = 0; tdata = 0; FSM = IDLE.
//  - Coefficient bank is NOT reset.
//  FSM: IDLE -> PREF -> STREAM -> CFG -> DONE -> IDLE.
//  - IDLE: reload_start_i=1 latches cfg_sel_i, clears rd_ptr, sets busy_o. Start while busy is ignored.
//  - PREF: bank read has 1-cycle latency. The first reload tvalid is asserted 2 cycles after the start cycle.
//  - STREAM: one word per cycle while tready=1, with a 2-entry prefetch and no bubbles.
//    Once tvalid=1, tdata and tlast hold until the handshake.
//    The handshake on word NUM_TAPS-1 (tlast=1) moves the FSM to CFG the next cycle and drops reload tvalid.
//  - CFG: config tvalid=1 with tdata = latched cfg_sel, held until tready.
//  - DONE: done_o=1 for one cycle, busy_o=0 in that same cycle, then IDLE.
//  Boundary conditions
//  - tready low any cycle: stall, no word lost or duplicated. rd_ptr wraps only through FSM exit, never modulo.
//  - coef_wr_en_i while busy_o=1: write dropped, err_o[2] set. Writes in IDLE take effect next cycle.
//  - Write and start in the same cycle: the write lands and the new value is streamed.
//  - event inputs set err_o[1:0] in any state. The sequence is not aborted.
//  - err_clr_i and a new event in the same cycle: set wins.
//  - rstn_i low mid-packet: tvalid drops asynchronously. The FIR sees a truncated packet, which is the host's concern.
// STRUCTURE
//  - fir_pkg: COEF_W, CFG_W defaults, the state encoding localparams (IDLE..DONE) and the err bit indices.
//  - Sub-module fir_coef_ram: NUM_TAPS x COEF_W simple dual-port RAM with a 1-cycle sync read. It infers BRAM/LUTRAM.
//  - The top holds the FSM, rd_ptr, prefetch buffer, config register and error flags.
// TESTING
//  1. Write taps 0..31 = 0x0100+i, pulse start with cfg_sel=1, tready=1
//     -> 32 consecutive beats 0x0100..0x011F, tlast on beat 31.
//     -> One config beat with tdata=0x01, then a single done_o pulse.
//  2. As in 1, with tready toggled randomly at 50%
//     -> identical beat sequence, AXI stability checked on every stalled beat.
//  3. Pulse start again while busy, and write tap 5 while busy
//     -> second start ignored, tap 5 unchanged on next reload, err_o=3'b100.
//     -> err_clr_i then gives err_o=0.
//  4. Assert rstn_i low at beat 10
//     -> tvalid=0 immediately, busy_o=0.
//     -> A fresh start after release streams the full 32 beats from tap 0.
//  5. Pulse event_tlast_unexpected_i during STREAM
//     -> err_o[1]=1, sequence still completes with done_o.
//  6. Hold config tready=0 for 20 cycles
//     -> config tvalid and tdata stable, done_o one cycle after tready rises.

Source files
------------

// File: rtl/fir_coef_reload_ctrl_pkg.sv
// Shared constants for the FIR coefficient reload controller: default widths,
// FSM state encoding and error-flag bit positions.
package fir_coef_reload_ctrl_pkg;

   localparam int NUM_TAPS_DEF = 32;
   localparam int COEF_W_DEF   = 16;
   localparam int CFG_W_DEF    = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PREF   = 3'd1,
      ST_STREAM = 3'd2,
      ST_CFG    = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // err_o bit positions
   localparam int ERR_TLAST_MISSING = 0;
   localparam int ERR_TLAST_UNEXP   = 1;
   localparam int ERR_WR_BUSY       = 2;
   localparam int ERR_W             = 3;

endpackage

// File: rtl/fir_coef_reload_ctrl_if.sv
// AXI-Stream pair toward the FIR compiler: reload packet channel and config channel.
interface fir_coef_reload_ctrl_if
   import fir_coef_reload_ctrl_pkg::*;
#(
   parameter int COEF_W = COEF_W_DEF,
   parameter int CFG_W  = CFG_W_DEF
);
   logic [COEF_W-1:0] reload_tdata;
   logic              reload_tvalid;
   logic              reload_tlast;
   logic              reload_tready;
   logic [CFG_W-1:0]  config_tdata;
   logic              config_tvalid;
   logic              config_tready;

   modport master (
      output reload_tdata, reload_tvalid, reload_tlast, config_tdata, config_tvalid,
      input  reload_tready, config_tready
   );

   modport slave (
      input  reload_tdata, reload_tvalid, reload_tlast, config_tdata, config_tvalid,
      output reload_tready, config_tready
   );
endinterface

// File: rtl/fir_coef_reload_ctrl_ram.sv
// Coefficient bank: simple dual-port RAM, one write port, one read port with a
// registered (1-cycle) read. No reset so it maps onto block/distributed RAM.
module fir_coef_reload_ctrl_ram #(
   parameter  int NUM_TAPS = 32,
   parameter  int COEF_W   = 16,
   localparam int AW       = $clog2(NUM_TAPS)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [COEF_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [COEF_W-1:0] rdata_o
);
   logic [COEF_W-1:0] mem_q [NUM_TAPS];
   logic [COEF_W-1:0] rdata_q;

   // write port and registered read port
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/fir_coef_reload_ctrl.sv
// Streams the coefficient bank to the FIR reload channel as one packet, then
// issues one config word. A 2-entry prefetch buffer with a fall-through path
// from the RAM output hides the read latency, so beats flow back to back and
// stalls never lose or repeat a word.
module fir_coef_reload_ctrl
   import fir_coef_reload_ctrl_pkg::*;
#(
   parameter  int NUM_TAPS = NUM_TAPS_DEF,
   parameter  int COEF_W   = COEF_W_DEF,
   parameter  int CFG_W    = CFG_W_DEF,
   localparam int AW       = $clog2(NUM_TAPS)
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  coef_wr_en_i,
   input  logic [AW-1:0]         coef_wr_addr_i,
   input  logic [COEF_W-1:0]     coef_wr_data_i,
   input  logic                  reload_start_i,
   input  logic [CFG_W-1:0]      cfg_sel_i,
   fir_coef_reload_ctrl_if.master m_axis,
   input  logic                  event_tlast_missing_i,
   input  logic                  event_tlast_unexpected_i,
   input  logic                  err_clr_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [ERR_W-1:0]      err_o
);
   state_e            state_q, state_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic              rd_done_q, rd_done_d;
   logic              inflight_q, inflight_d;
   logic              inflight_last_q, inflight_last_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [COEF_W-1:0] ent_data_q [2];
   logic [COEF_W-1:0] ent_data_d [2];
   logic              ent_last_q [2];
   logic              ent_last_d [2];
   logic [CFG_W-1:0]  cfg_q, cfg_d;
   logic [ERR_W-1:0]  err_q, err_d;

   logic [COEF_W-1:0] ram_rdata;
   logic              ram_we;
   logic              rd_issue;
   logic              busy;
   logic              rel_tvalid;
   logic              head_last;
   logic              pop;
   logic              pop_fifo;
   logic              push_fifo;
   logic [1:0]        cnt_pop;

   fir_coef_reload_ctrl_ram #(
      .NUM_TAPS (NUM_TAPS),
      .COEF_W   (COEF_W)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .waddr_i (coef_wr_addr_i),
      .wdata_i (coef_wr_data_i),
      .re_i    (rd_issue),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   // state register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // head-of-stream view: buffered entry first, else the word arriving from RAM
   always_comb begin
      busy       = (state_q == ST_PREF) || (state_q == ST_STREAM) || (state_q == ST_CFG);
      rel_tvalid = (state_q == ST_STREAM) && ((cnt_q != 2'd0) || inflight_q);
      head_last  = (cnt_q != 2'd0) ? ent_last_q[0] : inflight_last_q;
      pop        = rel_tvalid && m_axis.reload_tready;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (reload_start_i) state_d = ST_PREF;
         ST_PREF:   state_d = ST_STREAM;
         ST_STREAM: if (pop && head_last) state_d = ST_CFG;
         ST_CFG:    if (m_axis.config_tready) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // prefetch: a read is issued only if its word is sure to find a free slot
   always_comb begin
      rd_ptr_d        = rd_ptr_q;
      rd_done_d       = rd_done_q;
      cfg_d           = cfg_q;
      ent_data_d      = ent_data_q;
      ent_last_d      = ent_last_q;
      pop_fifo        = pop && (cnt_q != 2'd0);
      push_fifo       = inflight_q && !(pop && (cnt_q == 2'd0));
      cnt_pop         = cnt_q - {1'b0, pop_fifo};
      if (pop_fifo) begin
         ent_data_d[0] = ent_data_q[1];
         ent_last_d[0] = ent_last_q[1];
      end
      if (push_fifo) begin
         ent_data_d[cnt_pop[0]] = ram_rdata;
         ent_last_d[cnt_pop[0]] = inflight_last_q;
      end
      cnt_d           = cnt_pop + {1'b0, push_fifo};
      rd_issue        = ((state_q == ST_PREF) || (state_q == ST_STREAM)) && !rd_done_q
                        && (cnt_d <= 2'd1);
      inflight_d      = rd_issue;
      inflight_last_d = rd_issue && (rd_ptr_q == AW'(NUM_TAPS - 1));
      // rd_ptr parks on the last tap; only a new start rewinds it
      if (rd_issue) begin
         if (rd_ptr_q == AW'(NUM_TAPS - 1)) rd_done_d = 1'b1;
         else                               rd_ptr_d  = rd_ptr_q + AW'(1);
      end
      if ((state_q == ST_IDLE) && reload_start_i) begin
         rd_ptr_d   = '0;
         rd_done_d  = 1'b0;
         cfg_d      = cfg_sel_i;
         cnt_d      = 2'd0;
         inflight_d = 1'b0;
      end
   end

   // sticky error flags; a new event beats a simultaneous clear
   always_comb begin
      err_d                    = err_clr_i ? '0 : err_q;
      err_d[ERR_TLAST_MISSING] = err_d[ERR_TLAST_MISSING] | event_tlast_missing_i;
      err_d[ERR_TLAST_UNEXP]   = err_d[ERR_TLAST_UNEXP]   | event_tlast_unexpected_i;
      err_d[ERR_WR_BUSY]       = err_d[ERR_WR_BUSY]       | (coef_wr_en_i && busy);
      ram_we                   = coef_wr_en_i && !busy;
   end

   // datapath registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rd_ptr_q        <= '0;
         rd_done_q       <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         cnt_q           <= 2'd0;
         ent_data_q[0]   <= '0;
         ent_data_q[1]   <= '0;
         ent_last_q[0]   <= 1'b0;
         ent_last_q[1]   <= 1'b0;
         cfg_q           <= '0;
         err_q           <= '0;
      end else begin
         rd_ptr_q        <= rd_ptr_d;
         rd_done_q       <= rd_done_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         cnt_q           <= cnt_d;
         ent_data_q      <= ent_data_d;
         ent_last_q      <= ent_last_d;
         cfg_q           <= cfg_d;
         err_q           <= err_d;
      end
   end

   // outputs decoded from state and the prefetch head
   always_comb begin
      m_axis.reload_tvalid = rel_tvalid;
      m_axis.reload_tlast  = rel_tvalid && head_last;
      m_axis.reload_tdata  = '0;
      if (rel_tvalid) m_axis.reload_tdata = (cnt_q != 2'd0) ? ent_data_q[0] : ram_rdata;
      m_axis.config_tvalid = (state_q == ST_CFG);
      m_axis.config_tdata  = cfg_q;
      busy_o               = busy;
      done_o               = (state_q == ST_DONE);
      err_o                = err_q;
   end
endmodule
